// File: rtl/wb_rr_arbiter_pkg.sv
// wb_rr_arbiter_pkg: shared state encoding, master indices and round-robin pick
package wb_rr_arbiter_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GNT = 2'd1, ST_ABORT = 2'd2} arb_state_e;
   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;
   // a lone requester wins; on a tie the master that did not win last time wins
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      return (req == 2'b11) ? ~last : req[1];
   endfunction
endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: stall counter with expiry strobe and saturating event count
module wb_arb_watchdog #(
   parameter int TIMEOUT = 256,
   parameter int TOCNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic               clr,
   output logic               expire_o,
   output logic [TOCNT_W-1:0] cnt_o
);
   localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic [TOCNT_W-1:0] cnt_q, cnt_d;
   // expiry fires on the TIMEOUT-th consecutive unanswered strobe cycle
   always_comb begin
      expire_o = run && (wd_q == WD_W'(TIMEOUT - 1));
      wd_d     = (clr || expire_o) ? '0 : run ? wd_q + 1'b1 : wd_q;
      cnt_d    = (expire_o && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   // counter state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wd_q  <= wd_d;
         cnt_q <= cnt_d;
      end
   end
   assign cnt_o = cnt_q;
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master round-robin Wishbone arbiter with slave watchdog
module wb_rr_arbiter
   import wb_rr_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 256,
   parameter int TOCNT_W = 16
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_n_i,
   input  logic [1:0]         m_cyc_i,
   input  logic [1:0]         m_stb_i,
   input  logic [1:0]         m_we_i,
   input  logic [7:0]         m_sel_i,
   input  logic [63:0]        m_adr_i,
   input  logic [63:0]        m_dat_i,
   output logic [31:0]        m_dat_o,
   output logic [1:0]         m_ack_o,
   output logic [1:0]         m_err_o,
   output logic               s_cyc_o,
   output logic               s_stb_o,
   output logic               s_we_o,
   output logic [3:0]         s_sel_o,
   output logic [31:0]        s_adr_o,
   output logic [31:0]        s_dat_o,
   input  logic [31:0]        s_dat_i,
   input  logic               s_ack_i,
   input  logic               s_err_i,
   output logic [1:0]         gnt_o,
   output logic [TOCNT_W-1:0] timeout_cnt_o
);
   arb_state_e state_q, state_d;
   logic       idx_q, idx_d;
   logic       last_q, last_d;
   logic [1:0] gnt_q, gnt_d;
   logic [1:0] req;
   logic       gnt_act, expire;
   // next grant: arbitrate only from IDLE, hold the owner for its whole cycle
   always_comb begin
      req     = m_cyc_i & m_stb_i;
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      unique case (state_q)
         ST_IDLE: if (|req) begin
            state_d = ST_GNT;
            idx_d   = rr_pick(req, last_q);
            last_d  = idx_d;
         end
         ST_GNT:   state_d = !m_cyc_i[idx_q] ? ST_IDLE : expire ? ST_ABORT : ST_GNT;
         ST_ABORT: state_d = !m_cyc_i[idx_q] ? ST_IDLE : ST_ABORT;
         default:  state_d = ST_IDLE;
      endcase
      gnt_d = (state_d == ST_IDLE) ? 2'b00 : {idx_d == M1, idx_d == M0};
   end
   // arbiter state and registered grant
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q <= ST_IDLE;
         idx_q   <= M0;
         last_q  <= M1;
         gnt_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
      end
   end
   // slave-side mux and master-side response steering, only while in GNT
   always_comb begin
      gnt_act = (state_q == ST_GNT);
      s_cyc_o = gnt_act & m_cyc_i[idx_q];
      s_stb_o = s_cyc_o & m_stb_i[idx_q];
      s_we_o  = gnt_act & m_we_i[idx_q];
      s_sel_o = !gnt_act ? 4'h0 : idx_q ? m_sel_i[7:4] : m_sel_i[3:0];
      s_adr_o = !gnt_act ? 32'h0 : idx_q ? m_adr_i[63:32] : m_adr_i[31:0];
      s_dat_o = !gnt_act ? 32'h0 : idx_q ? m_dat_i[63:32] : m_dat_i[31:0];
      m_dat_o = s_dat_i;
      m_ack_o = (gnt_act & s_ack_i) ? gnt_q : 2'b00;
      m_err_o = (gnt_act & (s_err_i | expire)) ? gnt_q : 2'b00;
   end
   wb_arb_watchdog #(.TIMEOUT(TIMEOUT), .TOCNT_W(TOCNT_W)) u_wd (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_n_i),
      .run      (s_stb_o & ~s_ack_i & ~s_err_i),
      .clr      (~gnt_act | s_ack_i | s_err_i),
      .expire_o (expire),
      .cnt_o    (timeout_cnt_o)
   );
   assign gnt_o = gnt_q;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: directed and random checks against a cycle-level ownership model
module tb_wb_rr_arbiter;
   localparam int TO = 4;
   localparam int TW = 3;
   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o, gnt_o;
   logic [7:0]    m_sel_i;
   logic [63:0]   m_adr_i, m_dat_i;
   logic [31:0]   m_dat_o, s_adr_o, s_dat_o, s_dat_i;
   logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
   logic [3:0]    s_sel_o;
   logic [TW-1:0] timeout_cnt_o;

   wb_rr_arbiter #(.TIMEOUT(TO), .TOCNT_W(TW)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
      .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o), .timeout_cnt_o(timeout_cnt_o)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   // model: who owns the bus (-1 none), whether that ownership was aborted,
   // who won last, consecutive unanswered strobe cycles, watchdog events
   int owner, last, stall, tocnt, smode;
   bit aborted, prev_stb, prev_ack;
   logic [1:0]  obs_gnt, obs_ack, obs_err;
   logic        obs_stb, obs_cyc, obs_we;
   logic [31:0] obs_adr, obs_dat;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      owner = -1; aborted = 0; last = 1; stall = 0; tocnt = 0;
      prev_stb = 0; prev_ack = 0;
   endtask

   // one clock: slave responds, outputs are checked mid-cycle, model advances at the edge
   task automatic step();
      int o;
      bit ecyc, estb, expx;
      logic [1:0] ea, ee, eg, req;
      case (smode)
         0: begin s_ack_i = prev_stb && !prev_ack; s_err_i = 0; end
         1: begin s_ack_i = 0; s_err_i = 0; end
         2: begin s_ack_i = ($urandom_range(7) == 0); s_err_i = ($urandom_range(15) == 0); s_dat_i = $urandom; end
         3: begin s_ack_i = (stall == TO - 1); s_err_i = 0; end
         default: begin s_ack_i = 1; s_err_i = 0; end
      endcase
      #2;
      o    = aborted ? -1 : owner;
      ecyc = (o >= 0) && m_cyc_i[o];
      estb = ecyc && m_stb_i[o];
      expx = estb && !s_ack_i && !s_err_i && (stall == TO - 1);
      ea = 0; ee = 0; eg = 0;
      if (o >= 0) begin ea[o] = s_ack_i; ee[o] = s_err_i | expx; end
      if (owner >= 0) eg[owner] = 1'b1;
      check("gnt", gnt_o, eg);
      check("s_cyc", s_cyc_o, ecyc);
      check("s_stb", s_stb_o, estb);
      check("s_we", s_we_o, (o >= 0) ? m_we_i[o] : 1'b0);
      check("s_sel", s_sel_o, (o >= 0) ? m_sel_i[4*o +: 4] : 4'h0);
      check("s_adr", s_adr_o, (o >= 0) ? m_adr_i[32*o +: 32] : 32'h0);
      check("s_dat", s_dat_o, (o >= 0) ? m_dat_i[32*o +: 32] : 32'h0);
      check("m_ack", m_ack_o, ea);
      check("m_err", m_err_o, ee);
      check("m_dat", m_dat_o, s_dat_i);
      check("tocnt", timeout_cnt_o, tocnt);
      obs_gnt = gnt_o; obs_ack = m_ack_o; obs_err = m_err_o; obs_stb = s_stb_o;
      obs_cyc = s_cyc_o; obs_we = s_we_o; obs_adr = s_adr_o; obs_dat = m_dat_o;
      @(posedge clk);
      prev_stb = estb; prev_ack = s_ack_i;
      if (!rst_n) model_reset();
      else if (owner < 0) begin
         req = m_cyc_i & m_stb_i;
         if (req == 2'b11) owner = 1 - last;
         else if (req != 0) owner = req[1];
         if (owner >= 0) last = owner;
      end else if (!m_cyc_i[owner]) begin
         owner = -1; aborted = 0; stall = 0;
      end else if (expx) begin
         aborted = 1; stall = 0;
         if (tocnt < (1 << TW) - 1) tocnt++;
      end else if (!aborted) begin
         if (s_ack_i || s_err_i) stall = 0;
         else if (estb) stall++;
      end
      #1;
   endtask

   initial begin
      int n, w, tc0;
      rst_n = 0; m_cyc_i = 0; m_stb_i = 0; m_we_i = 0; m_sel_i = 8'hF1;
      m_adr_i = 0; m_dat_i = 64'h1111_2222_3333_4444; s_dat_i = 32'hB0A4D001;
      s_ack_i = 0; s_err_i = 0; smode = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      step();
      rst_n = 1;
      // single M0 read: stb one cycle after request, ack and data the cycle after
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      step();
      step();
      check("t1_stb", obs_stb, 1'b1);
      step();
      check("t1_ack", obs_ack, 2'b01);
      check("t1_dat", obs_dat, 32'hB0A4D001);
      m_cyc_i = 0; m_stb_i = 0;
      step();
      // fresh reset, then both request repeatedly: grants alternate starting at M0
      rst_n = 0; step(); rst_n = 1;
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      for (int r = 0; r < 4; r++) begin
         n = 0;
         do begin step(); n++; end while (obs_ack == 0 && n < 10);
         check("t2_order", obs_ack, (r % 2) ? 2'b10 : 2'b01);
         w = obs_ack[1];
         m_cyc_i[w] = 0; m_stb_i[w] = 0;
         step();
         m_cyc_i[w] = 1; m_stb_i[w] = 1;
      end
      m_cyc_i = 0; m_stb_i = 0;
      step(); step();
      // M1 holds cyc over three write beats while M0 waits
      m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b10; m_adr_i[63:32] = 32'h40;
      step();
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      for (int b = 0; b < 3; b++) begin
         m_adr_i[63:32] = 32'h40 + 4 * b;
         m_dat_i[63:32] = 32'hD0 + b;
         n = 0;
         do begin step(); n++; end while (obs_ack == 0 && n < 10);
         check("t3_adr", obs_adr, 32'h40 + 4 * b);
         check("t3_we", obs_we, 1'b1);
         check("t3_gnt", obs_gnt, 2'b10);
      end
      m_cyc_i[1] = 0; m_stb_i[1] = 0;
      step(); step(); step();
      check("t3_m0", obs_gnt, 2'b01);
      m_cyc_i = 0; m_stb_i = 0; m_we_i = 0;
      step(); step();
      // slave never answers: err on the TIMEOUT-th strobe cycle, then abort
      smode = 1; tc0 = tocnt;
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      step();
      for (int k = 0; k < TO; k++) begin
         step();
         check("t4_stb", obs_stb, 1'b1);
         check("t4_err", obs_err, (k == TO - 1) ? 2'b01 : 2'b00);
      end
      smode = 4;
      step();
      check("t4_abort_stb", obs_stb, 1'b0);
      check("t4_late_ack", obs_ack, 2'b00);
      check("t4_cnt", timeout_cnt_o, tc0 + 1);
      smode = 0; m_cyc_i = 0; m_stb_i = 0;
      step(); step();
      // ack arrives in the expiry cycle: ordinary ack, no err, count unchanged
      smode = 3; tc0 = tocnt;
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      step();
      for (int k = 0; k < TO; k++) step();
      check("t5_ack", obs_ack, 2'b01);
      check("t5_err", obs_err, 2'b00);
      smode = 0; m_cyc_i = 0; m_stb_i = 0;
      step();
      check("t5_cnt", timeout_cnt_o, tc0);
      step();
      // reset in the middle of a granted cycle
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      step(); step();
      rst_n = 0; m_cyc_i = 2'b11; m_stb_i = 2'b11;
      step();
      rst_n = 1;
      step();
      check("t6_gnt", obs_gnt, 2'b00);
      check("t6_cyc", obs_cyc, 1'b0);
      check("t6_resp", {obs_ack, obs_err}, 4'h0);
      step();
      check("t6_win", obs_gnt, 2'b01);
      // random traffic with sticky request lines and a flaky slave
      smode = 2;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 2; k++) begin
            if ($urandom_range(7) == 0) m_cyc_i[k] = ~m_cyc_i[k];
            if ($urandom_range(3) == 0) m_stb_i[k] = ~m_stb_i[k];
         end
         m_we_i = 2'($urandom); m_sel_i = 8'($urandom);
         m_adr_i = {$urandom, $urandom}; m_dat_i = {$urandom, $urandom};
         rst_n = ($urandom_range(499) != 0);
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
